alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Decode/issue stage directly upstream of the execute ALU.
- Accepts one RV32I instruction per cycle with its register-file operands and PC, and resolves EX and WB forwarding.
- Generates the 6-bit ALU control code and both ALU operands, and holds them in a 2-entry skid buffer with valid/ready handshakes on both sides.
- Outputs feed the ALU inputs (srca, srcb, aluCtrl) and the sideband consumed by the branch/writeback logic.

Parameters:
- XLEN, 32, datapath width.
- RESET_PC, 32'h0000_0000, reset value of outPc.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- inValid  in  1  upstream instruction valid.
- inReady  out  1  stage can accept; registered.
- inInstr  in  32  raw instruction.
- inPc  in  XLEN  instruction PC.
- rs1Data  in  XLEN  register-file read of rs1.
- rs2Data  in  XLEN  register-file read of rs2.
- exFwdEn  in  1  EX result writes a register.
- exFwdRd  in  5  EX destination register.
- exFwdData  in  XLEN  EX result.
- wbFwdEn  in  1  WB writes a register.
- wbFwdRd  in  5  WB destination register.
- wbFwdData  in  XLEN  WB result.
- flush  in  1  branch-mispredict kill.
- outValid  out  1  issue entry valid.
- outReady  in  1  ALU stage accepts.
- aluCtrl  out  6  ALU operation code.
- srca  out  XLEN  ALU operand A.
- srcb  out  XLEN  ALU operand B.
- outRs2  out  XLEN  forwarded rs2, used as store data.
- outRd  out  5  destination register.
- outRegWrite  out  1  instruction writes outRd.
- outIsBranch  out  1  conditional branch; ALU bit 30 means taken.
- outPc  out  XLEN  PC of the issued entry.
- illegal  out  1  pulses for one cycle when an illegal opcode is dropped.

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous and active-low.
- Reset values: outValid=0, inReady=1, illegal=0, outPc=RESET_PC; all other outputs 0; skid buffer empty.
- Acceptance: an instruction is accepted when inValid && inReady. Forwarding is resolved at acceptance.
  - Operand priority: EX over WB over register file.
  - A source equal to x0 never forwards and reads 0.
- Decode by opcode:
  - OP: srca=rs1, srcb=rs2. funct3/funct7 select add=0, sub=1, xor=2, sll=3, slt=4, srl=5, sra=6, and=7, or=8, sltu=13.
  - OP-IMM: srcb = sign-extended I-immediate. No subi; funct7[5] is used only for srai.
  - Shifts (register or immediate): srcb[31:5] forced to 0.
  - BRANCH: srca=rs1, srcb=rs2. beq=9, bne=10, blt=11, bge=12, bltu=14, bgeu=15. outRegWrite=0, outIsBranch=1.
  - LOAD/STORE: add, srca=rs1, srcb=I/S-immediate. STORE has outRegWrite=0.
  - LUI: add, srca=0, srcb=U-immediate.
  - AUIPC: add, srca=pc, srcb=U-immediate.
  - JAL/JALR: add, srca=pc, srcb=4 (link value).
  - Any other opcode: entry not stored; illegal=1 next cycle.
- Skid buffer FSM (inReady = state != FULL, registered):
  - EMPTY: accept -> BUSY, entry goes to the output register.
  - BUSY, accept && !outReady -> FULL, entry goes to the skid register.
  - BUSY, !accept && outReady -> EMPTY.
  - BUSY, accept && outReady -> BUSY, output register reloaded.
  - FULL, outReady -> BUSY, skid moves to output. No accept is possible in FULL.
- Output stability: while outValid && !outReady, all out* signals hold their values.
- Latency: 1 cycle from acceptance to outValid when EMPTY. Throughput is 1 per cycle with outReady held high.
- flush has priority over every transition:
  - Next state is EMPTY; both entries and any same-cycle acceptance are discarded.
  - illegal is suppressed.
- Reset asserted mid-operation clears both entries immediately; no partial entry survives.

Decomposition:
- Package alu_pkg holds:
  - ALU control localparams 0..15 (shared with the ALU).
  - RV32I opcode constants.
  - Operand-select enums: A = {RS1, PC, ZERO}, B = {RS2, IMM, FOUR}.
- Sub-module alu_issue_decode (combinational) maps instr to aluCtrl, immediate, selects, regWrite, isBranch and illegal.
- The top level holds forwarding muxes, operand muxes, the skid buffer and the FSM.

Test Plan:
- add x3,x1,x2 with rs1Data=5, rs2Data=7, outReady=1 -> next cycle outValid=1, aluCtrl=0, srca=5, srcb=7, outRd=3, outRegWrite=1.
- sub x3,x1,x2 with exFwdEn=1, exFwdRd=1, exFwdData=100 and wbFwdEn=1, wbFwdRd=1, wbFwdData=50 -> aluCtrl=1, srca=100 (EX wins). Repeat with rs1=x0 -> srca=0.
- sll x4,x5,x6 with rs2Data=32'hFFFF_FFE3 -> aluCtrl=3, srcb=3. srai x4,x5,4 -> aluCtrl=6, srcb=4.
- bltu x1,x2 -> aluCtrl=14, outIsBranch=1, outRegWrite=0. jal at pc=0x100 -> aluCtrl=0, srca=0x100, srcb=4.
- Backpressure: 3 back-to-back instructions with outReady=0 -> first in the output register, second in skid, inReady=0 on cycle 2. Raise outReady -> all three issue in order with no loss or duplication.
- FULL state with flush=1 and inValid=1 -> next cycle outValid=0, inReady=1. Opcode 7'b1111111 -> illegal=1 for one cycle, outValid remains 0.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Definitions shared by the issue stage and the execute ALU:
//   - ALU control codes 0..15
//   - RV32I major opcode constants
//   - operand-select enums for ALU inputs A and B
//   - skid-buffer state encoding
// -----------------------------------------------------------------------------
package alu_pkg;

  // ALU control codes; codes 9..12, 14 and 15 are branch compares, and the
  // ALU reports "taken" on bit 30 of its result for those.
  localparam logic [5:0] ALU_ADD  = 6'd0;
  localparam logic [5:0] ALU_SUB  = 6'd1;
  localparam logic [5:0] ALU_XOR  = 6'd2;
  localparam logic [5:0] ALU_SLL  = 6'd3;
  localparam logic [5:0] ALU_SLT  = 6'd4;
  localparam logic [5:0] ALU_SRL  = 6'd5;
  localparam logic [5:0] ALU_SRA  = 6'd6;
  localparam logic [5:0] ALU_AND  = 6'd7;
  localparam logic [5:0] ALU_OR   = 6'd8;
  localparam logic [5:0] ALU_BEQ  = 6'd9;
  localparam logic [5:0] ALU_BNE  = 6'd10;
  localparam logic [5:0] ALU_BLT  = 6'd11;
  localparam logic [5:0] ALU_BGE  = 6'd12;
  localparam logic [5:0] ALU_SLTU = 6'd13;
  localparam logic [5:0] ALU_BLTU = 6'd14;
  localparam logic [5:0] ALU_BGEU = 6'd15;

  // RV32I major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {SEL_A_RS1, SEL_A_PC, SEL_A_ZERO} sel_a_e;
  typedef enum logic [1:0] {SEL_B_RS2, SEL_B_IMM, SEL_B_FOUR} sel_b_e;
  typedef enum logic [1:0] {ST_EMPTY, ST_BUSY, ST_FULL} skid_state_e;

  // ALU code for OP / OP-IMM. alt_bit is funct7[5]; it selects sub only for
  // the register form (allow_sub), while it always selects sra on funct3=101.
  function automatic logic [5:0] arith_ctrl(input logic [2:0] funct3,
                                            input logic       alt_bit,
                                            input logic       allow_sub);
    logic [5:0] ctrl;
    case (funct3)
      3'b000:  ctrl = (allow_sub && alt_bit) ? ALU_SUB : ALU_ADD;
      3'b001:  ctrl = ALU_SLL;
      3'b010:  ctrl = ALU_SLT;
      3'b011:  ctrl = ALU_SLTU;
      3'b100:  ctrl = ALU_XOR;
      3'b101:  ctrl = alt_bit ? ALU_SRA : ALU_SRL;
      3'b110:  ctrl = ALU_OR;
      3'b111:  ctrl = ALU_AND;
      default: ctrl = ALU_ADD;
    endcase
    return ctrl;
  endfunction

  // ALU compare code for a conditional branch funct3.
  function automatic logic [5:0] branch_ctrl(input logic [2:0] funct3);
    logic [5:0] ctrl;
    case (funct3)
      3'b000:  ctrl = ALU_BEQ;
      3'b001:  ctrl = ALU_BNE;
      3'b100:  ctrl = ALU_BLT;
      3'b101:  ctrl = ALU_BGE;
      3'b110:  ctrl = ALU_BLTU;
      3'b111:  ctrl = ALU_BGEU;
      default: ctrl = ALU_BEQ;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// -----------------------------------------------------------------------------
// alu_issue_decode
// Purely combinational RV32I decode for the issue stage.
// Ports:
//   instr      in   raw 32-bit instruction
//   alu_ctrl   out  ALU control code
//   imm        out  sign-extended immediate (I, S or U form as the opcode needs)
//   sel_a      out  operand A source (rs1 / pc / zero)
//   sel_b      out  operand B source (rs2 / imm / constant 4)
//   reg_write  out  instruction writes rd
//   is_branch  out  conditional branch
//   is_shift   out  shift op: operand B must be masked to 5 bits
//   illegal    out  opcode not recognised
// -----------------------------------------------------------------------------
module alu_issue_decode
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [5:0]      alu_ctrl,
  output logic [XLEN-1:0] imm,
  output sel_a_e          sel_a,
  output sel_b_e          sel_b,
  output logic            reg_write,
  output logic            is_branch,
  output logic            is_shift,
  output logic            illegal
);

  logic [6:0]         opcode_s;
  logic [2:0]         funct3_s;
  logic               shift_f3_s;
  logic signed [31:0] imm_i_s;
  logic signed [31:0] imm_s_s;
  logic signed [31:0] imm_u_s;
  logic signed [31:0] imm_sel_s;

  assign opcode_s   = instr[6:0];
  assign funct3_s   = instr[14:12];
  assign shift_f3_s = (funct3_s == 3'b001) || (funct3_s == 3'b101);
  assign imm_i_s    = {{20{instr[31]}}, instr[31:20]};
  assign imm_s_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u_s    = {instr[31:12], 12'h000};

  // Signed cast extends the 32-bit immediate to the datapath width.
  assign imm = XLEN'(imm_sel_s);

  // Opcode decode into ALU code, operand selects and sideband flags.
  always_comb begin
    alu_ctrl  = ALU_ADD;
    imm_sel_s = 32'sd0;
    sel_a     = SEL_A_RS1;
    sel_b     = SEL_B_RS2;
    reg_write = 1'b0;
    is_branch = 1'b0;
    is_shift  = 1'b0;
    illegal   = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        alu_ctrl  = arith_ctrl(funct3_s, instr[30], 1'b1);
        reg_write = 1'b1;
        is_shift  = shift_f3_s;
      end
      OPC_OP_IMM: begin
        alu_ctrl  = arith_ctrl(funct3_s, instr[30], 1'b0);
        imm_sel_s = imm_i_s;
        sel_b     = SEL_B_IMM;
        reg_write = 1'b1;
        is_shift  = shift_f3_s;
      end
      OPC_BRANCH: begin
        alu_ctrl  = branch_ctrl(funct3_s);
        is_branch = 1'b1;
      end
      OPC_LOAD: begin
        imm_sel_s = imm_i_s;
        sel_b     = SEL_B_IMM;
        reg_write = 1'b1;
      end
      OPC_STORE: begin
        imm_sel_s = imm_s_s;
        sel_b     = SEL_B_IMM;
      end
      OPC_LUI: begin
        imm_sel_s = imm_u_s;
        sel_a     = SEL_A_ZERO;
        sel_b     = SEL_B_IMM;
        reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        imm_sel_s = imm_u_s;
        sel_a     = SEL_A_PC;
        sel_b     = SEL_B_IMM;
        reg_write = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        // The ALU computes the link value pc+4.
        sel_a     = SEL_A_PC;
        sel_b     = SEL_B_FOUR;
        reg_write = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
// Decode/issue stage feeding the execute ALU. Resolves EX/WB forwarding at
// acceptance, builds the ALU operands and control code, and holds issued
// entries in a 2-entry skid buffer (output register + skid register).
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   inValid/inReady             upstream handshake (inReady registered)
//   inInstr, inPc               instruction and its PC
//   rs1Data, rs2Data            register-file reads
//   exFwd*/wbFwd*               EX and WB forwarding sources
//   flush                       kills everything held and accepted this cycle
//   outValid/outReady           downstream handshake
//   aluCtrl, srca, srcb         ALU inputs
//   outRs2, outRd, outRegWrite, outIsBranch, outPc   sideband
//   illegal                     one-cycle pulse when an illegal opcode is dropped
// -----------------------------------------------------------------------------
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inValid,
  output logic            inReady,
  input  logic [31:0]     inInstr,
  input  logic [XLEN-1:0] inPc,
  input  logic [XLEN-1:0] rs1Data,
  input  logic [XLEN-1:0] rs2Data,
  input  logic            exFwdEn,
  input  logic [4:0]      exFwdRd,
  input  logic [XLEN-1:0] exFwdData,
  input  logic            wbFwdEn,
  input  logic [4:0]      wbFwdRd,
  input  logic [XLEN-1:0] wbFwdData,
  input  logic            flush,
  output logic            outValid,
  input  logic            outReady,
  output logic [5:0]      aluCtrl,
  output logic [XLEN-1:0] srca,
  output logic [XLEN-1:0] srcb,
  output logic [XLEN-1:0] outRs2,
  output logic [4:0]      outRd,
  output logic            outRegWrite,
  output logic            outIsBranch,
  output logic [XLEN-1:0] outPc,
  output logic            illegal
);

  typedef struct packed {
    logic [5:0]      ctrl;
    logic [XLEN-1:0] srca;
    logic [XLEN-1:0] srcb;
    logic [XLEN-1:0] rs2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            is_branch;
    logic [XLEN-1:0] pc;
  } entry_t;

  // EX beats WB beats register file; x0 always reads zero.
  function automatic logic [XLEN-1:0] fwd_operand(input logic [4:0]      src,
                                                  input logic [XLEN-1:0] rf_data,
                                                  input logic            ex_en,
                                                  input logic [4:0]      ex_rd,
                                                  input logic [XLEN-1:0] ex_data,
                                                  input logic            wb_en,
                                                  input logic [4:0]      wb_rd,
                                                  input logic [XLEN-1:0] wb_data);
    logic [XLEN-1:0] val;
    if (src == 5'd0) begin
      val = '0;
    end else if (ex_en && (ex_rd == src)) begin
      val = ex_data;
    end else if (wb_en && (wb_rd == src)) begin
      val = wb_data;
    end else begin
      val = rf_data;
    end
    return val;
  endfunction

  logic [5:0]      dec_ctrl_s;
  logic [XLEN-1:0] dec_imm_s;
  sel_a_e          dec_sel_a_s;
  sel_b_e          dec_sel_b_s;
  logic            dec_reg_write_s;
  logic            dec_is_branch_s;
  logic            dec_is_shift_s;
  logic            dec_illegal_s;

  logic [XLEN-1:0] rs1_fwd_s;
  logic [XLEN-1:0] rs2_fwd_s;
  logic [XLEN-1:0] opa_s;
  logic [XLEN-1:0] opb_raw_s;
  logic [XLEN-1:0] opb_s;
  entry_t          new_entry_s;

  skid_state_e     state_r;
  skid_state_e     state_next_s;
  logic            accept_s;
  logic            load_out_s;
  logic            load_skid_s;
  logic            out_from_skid_s;

  entry_t          out_r;
  entry_t          skid_r;
  logic            out_valid_r;
  logic            in_ready_r;
  logic            illegal_r;

  alu_issue_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .instr     (inInstr),
    .alu_ctrl  (dec_ctrl_s),
    .imm       (dec_imm_s),
    .sel_a     (dec_sel_a_s),
    .sel_b     (dec_sel_b_s),
    .reg_write (dec_reg_write_s),
    .is_branch (dec_is_branch_s),
    .is_shift  (dec_is_shift_s),
    .illegal   (dec_illegal_s)
  );

  assign rs1_fwd_s = fwd_operand(inInstr[19:15], rs1Data, exFwdEn, exFwdRd, exFwdData,
                                 wbFwdEn, wbFwdRd, wbFwdData);
  assign rs2_fwd_s = fwd_operand(inInstr[24:20], rs2Data, exFwdEn, exFwdRd, exFwdData,
                                 wbFwdEn, wbFwdRd, wbFwdData);

  // Illegal opcodes never enter the buffer.
  assign accept_s = inValid && in_ready_r && !dec_illegal_s;

  // Operand muxes; shifts only see the low 5 bits of operand B.
  always_comb begin
    opa_s     = '0;
    opb_raw_s = '0;
    case (dec_sel_a_s)
      SEL_A_RS1: opa_s = rs1_fwd_s;
      SEL_A_PC:  opa_s = inPc;
      default:   opa_s = '0;
    endcase
    case (dec_sel_b_s)
      SEL_B_RS2:  opb_raw_s = rs2_fwd_s;
      SEL_B_IMM:  opb_raw_s = dec_imm_s;
      SEL_B_FOUR: opb_raw_s = {{(XLEN-3){1'b0}}, 3'd4};
      default:    opb_raw_s = '0;
    endcase
    if (dec_is_shift_s) begin
      opb_s = {{(XLEN-5){1'b0}}, opb_raw_s[4:0]};
    end else begin
      opb_s = opb_raw_s;
    end
  end

  assign new_entry_s = '{ctrl:      dec_ctrl_s,
                         srca:      opa_s,
                         srcb:      opb_s,
                         rs2:       rs2_fwd_s,
                         rd:        inInstr[11:7],
                         reg_write: dec_reg_write_s,
                         is_branch: dec_is_branch_s,
                         pc:        inPc};

  // Skid-buffer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_next_s = state_r;
    if (flush) begin
      state_next_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) state_next_s = ST_BUSY;
          else          state_next_s = ST_EMPTY;
        end
        ST_BUSY: begin
          if (accept_s && !outReady)      state_next_s = ST_FULL;
          else if (!accept_s && outReady) state_next_s = ST_EMPTY;
          else                            state_next_s = ST_BUSY;
        end
        ST_FULL: begin
          if (outReady) state_next_s = ST_BUSY;
          else          state_next_s = ST_FULL;
        end
        default: state_next_s = ST_EMPTY;
      endcase
    end
  end

  // FSM outputs: which buffer register loads this cycle and from where.
  always_comb begin
    load_out_s      = 1'b0;
    load_skid_s     = 1'b0;
    out_from_skid_s = 1'b0;
    if (flush) begin
      load_out_s = 1'b0;
    end else begin
      case (state_r)
        ST_EMPTY: load_out_s = accept_s;
        ST_BUSY: begin
          if (accept_s && !outReady)     load_skid_s = 1'b1;
          else if (accept_s && outReady) load_out_s  = 1'b1;
          else                           load_out_s  = 1'b0;
        end
        ST_FULL: begin
          if (outReady) begin
            load_out_s      = 1'b1;
            out_from_skid_s = 1'b1;
          end else begin
            load_out_s = 1'b0;
          end
        end
        default: load_out_s = 1'b0;
      endcase
    end
  end

  // Buffer datapath and registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r       <= '0;
      out_r.pc    <= RESET_PC;
      skid_r      <= '0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      illegal_r   <= 1'b0;
    end else begin
      if (load_out_s) begin
        out_r <= out_from_skid_s ? skid_r : new_entry_s;
      end
      if (load_skid_s) begin
        skid_r <= new_entry_s;
      end
      out_valid_r <= (state_next_s != ST_EMPTY);
      in_ready_r  <= (state_next_s != ST_FULL);
      illegal_r   <= inValid && in_ready_r && dec_illegal_s && !flush;
    end
  end

  assign inReady     = in_ready_r;
  assign outValid    = out_valid_r;
  assign illegal     = illegal_r;
  assign aluCtrl     = out_r.ctrl;
  assign srca        = out_r.srca;
  assign srcb        = out_r.srcb;
  assign outRs2      = out_r.rs2;
  assign outRd       = out_r.rd;
  assign outRegWrite = out_r.reg_write;
  assign outIsBranch = out_r.is_branch;
  assign outPc       = out_r.pc;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        inValid;
  logic        inReady;
  logic [31:0] inInstr;
  logic [31:0] inPc;
  logic [31:0] rs1Data;
  logic [31:0] rs2Data;
  logic        exFwdEn;
  logic [4:0]  exFwdRd;
  logic [31:0] exFwdData;
  logic        wbFwdEn;
  logic [4:0]  wbFwdRd;
  logic [31:0] wbFwdData;
  logic        flush;
  logic        outValid;
  logic        outReady;
  logic [5:0]  aluCtrl;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic [31:0] outRs2;
  logic [4:0]  outRd;
  logic        outRegWrite;
  logic        outIsBranch;
  logic [31:0] outPc;
  logic        illegal;

  int checks;
  int errors;

  alu_issue_stage #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
    .inInstr(inInstr), .inPc(inPc), .rs1Data(rs1Data), .rs2Data(rs2Data),
    .exFwdEn(exFwdEn), .exFwdRd(exFwdRd), .exFwdData(exFwdData),
    .wbFwdEn(wbFwdEn), .wbFwdRd(wbFwdRd), .wbFwdData(wbFwdData),
    .flush(flush), .outValid(outValid), .outReady(outReady),
    .aluCtrl(aluCtrl), .srca(srca), .srcb(srcb), .outRs2(outRs2),
    .outRd(outRd), .outRegWrite(outRegWrite), .outIsBranch(outIsBranch),
    .outPc(outPc), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  // Present one instruction for a single cycle; outputs are valid on return.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2);
    inValid = 1'b1;
    inInstr = instr;
    inPc    = pc;
    rs1Data = r1;
    rs2Data = r2;
    @(posedge clk); #1;
    inValid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; inValid = 1'b0; inInstr = 32'h0; inPc = 32'h0;
    rs1Data = 32'h0; rs2Data = 32'h0; exFwdEn = 1'b0; exFwdRd = 5'd0;
    exFwdData = 32'h0; wbFwdEn = 1'b0; wbFwdRd = 5'd0; wbFwdData = 32'h0;
    flush = 1'b0; outReady = 1'b1;
    #12;
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_outValid: got %b exp 0", outValid); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL reset_inReady: got %b exp 1", inReady); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b exp 0", illegal); end
    checks++; if (outPc !== 32'h0) begin errors++; $display("FAIL reset_outPc: got %h exp 0", outPc); end
    checks++; if ({aluCtrl, srca, srcb, outRd} !== 75'd0) begin errors++; $display("FAIL reset_outputs: got nonzero ctrl=%0d srca=%h srcb=%h rd=%0d", aluCtrl, srca, srcb, outRd); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    send(enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011), 32'h40, 32'd5, 32'd7);
    checks++; if (outValid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b exp 1", outValid); end
    checks++; if (aluCtrl !== 6'd0) begin errors++; $display("FAIL add_ctrl: got %0d exp 0", aluCtrl); end
    checks++; if (srca !== 32'd5) begin errors++; $display("FAIL add_srca: got %h exp 5", srca); end
    checks++; if (srcb !== 32'd7) begin errors++; $display("FAIL add_srcb: got %h exp 7", srcb); end
    checks++; if (outRd !== 5'd3) begin errors++; $display("FAIL add_rd: got %0d exp 3", outRd); end
    checks++; if (outRegWrite !== 1'b1) begin errors++; $display("FAIL add_regwrite: got %b exp 1", outRegWrite); end
    checks++; if (outPc !== 32'h40) begin errors++; $display("FAIL add_pc: got %h exp 40", outPc); end
  endtask

  task automatic test_forward();
    exFwdEn = 1'b1; exFwdRd = 5'd1; exFwdData = 32'd100;
    wbFwdEn = 1'b1; wbFwdRd = 5'd1; wbFwdData = 32'd50;
    send(enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011), 32'h44, 32'd9, 32'd2);
    checks++; if (aluCtrl !== 6'd1) begin errors++; $display("FAIL sub_ctrl: got %0d exp 1", aluCtrl); end
    checks++; if (srca !== 32'd100) begin errors++; $display("FAIL fwd_ex_wins: got %0d exp 100", srca); end
    exFwdEn = 1'b0;
    send(enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011), 32'h48, 32'd9, 32'd2);
    checks++; if (srca !== 32'd50) begin errors++; $display("FAIL fwd_wb: got %0d exp 50", srca); end
    exFwdEn = 1'b1; exFwdRd = 5'd0; wbFwdRd = 5'd0;
    send(enc_r(7'b0100000, 5'd2, 5'd0, 3'b000, 5'd3, 7'b0110011), 32'h4C, 32'd77, 32'd2);
    checks++; if (srca !== 32'd0) begin errors++; $display("FAIL fwd_x0: got %0d exp 0", srca); end
    checks++; if (srcb !== 32'd2) begin errors++; $display("FAIL fwd_x0_srcb: got %0d exp 2", srcb); end
    exFwdEn = 1'b0; wbFwdEn = 1'b0;
  endtask

  task automatic test_shift_imm();
    send(enc_r(7'b0000000, 5'd6, 5'd5, 3'b001, 5'd4, 7'b0110011), 32'h50, 32'd1, 32'hFFFF_FFE3);
    checks++; if (aluCtrl !== 6'd3) begin errors++; $display("FAIL sll_ctrl: got %0d exp 3", aluCtrl); end
    checks++; if (srcb !== 32'd3) begin errors++; $display("FAIL sll_srcb: got %h exp 3", srcb); end
    checks++; if (outRs2 !== 32'hFFFF_FFE3) begin errors++; $display("FAIL sll_rs2: got %h exp ffffffe3", outRs2); end
    send(enc_i(12'h404, 5'd5, 3'b101, 5'd4, 7'b0010011), 32'h54, 32'd1, 32'd0);
    checks++; if (aluCtrl !== 6'd6) begin errors++; $display("FAIL srai_ctrl: got %0d exp 6", aluCtrl); end
    checks++; if (srcb !== 32'd4) begin errors++; $display("FAIL srai_srcb: got %h exp 4", srcb); end
    send(enc_i(12'hFFF, 5'd2, 3'b000, 5'd1, 7'b0010011), 32'h58, 32'd1, 32'd0);
    checks++; if (aluCtrl !== 6'd0) begin errors++; $display("FAIL addi_ctrl: got %0d exp 0", aluCtrl); end
    checks++; if (srcb !== 32'hFFFF_FFFF) begin errors++; $display("FAIL addi_imm: got %h exp ffffffff", srcb); end
  endtask

  task automatic test_branch_jump();
    send({7'b0, 5'd2, 5'd1, 3'b110, 5'd0, 7'b1100011}, 32'h60, 32'd11, 32'd22);
    checks++; if (aluCtrl !== 6'd14) begin errors++; $display("FAIL bltu_ctrl: got %0d exp 14", aluCtrl); end
    checks++; if (outIsBranch !== 1'b1) begin errors++; $display("FAIL bltu_isbranch: got %b exp 1", outIsBranch); end
    checks++; if (outRegWrite !== 1'b0) begin errors++; $display("FAIL bltu_regwrite: got %b exp 0", outRegWrite); end
    checks++; if ({srca, srcb} !== {32'd11, 32'd22}) begin errors++; $display("FAIL bltu_ops: got %h/%h exp b/16", srca, srcb); end
    send({20'd0, 5'd1, 7'b1101111}, 32'h100, 32'd9, 32'd9);
    checks++; if (aluCtrl !== 6'd0) begin errors++; $display("FAIL jal_ctrl: got %0d exp 0", aluCtrl); end
    checks++; if (srca !== 32'h100) begin errors++; $display("FAIL jal_srca: got %h exp 100", srca); end
    checks++; if (srcb !== 32'd4) begin errors++; $display("FAIL jal_srcb: got %h exp 4", srcb); end
    send({20'h12345, 5'd5, 7'b0110111}, 32'h104, 32'd9, 32'd9);
    checks++; if ({srca, srcb} !== {32'd0, 32'h1234_5000}) begin errors++; $display("FAIL lui_ops: got %h/%h exp 0/12345000", srca, srcb); end
    send(enc_s(12'd8, 5'd2, 5'd1, 3'b010), 32'h108, 32'd1000, 32'd5);
    checks++; if (srcb !== 32'd8) begin errors++; $display("FAIL sw_imm: got %h exp 8", srcb); end
    checks++; if (outRegWrite !== 1'b0) begin errors++; $display("FAIL sw_regwrite: got %b exp 0", outRegWrite); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] got [8];
    int          n;
    logic        sending;
    logic [31:0] add_i;
    add_i = enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011);
    n = 0;
    outReady = 1'b0;
    send(add_i, 32'h200, 32'd1, 32'd0);
    send(add_i, 32'h204, 32'd2, 32'd0);
    checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL bp_inready_full: got %b exp 0", inReady); end
    inValid = 1'b1; inInstr = add_i; inPc = 32'h208; rs1Data = 32'd3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (srca !== 32'd1 || outValid !== 1'b1) begin errors++; $display("FAIL bp_hold: got srca=%0d valid=%b exp 1/1", srca, outValid); end
    outReady = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (outValid && outReady && n < 8) begin
        got[n] = srca;
        n++;
      end
      sending = inValid && inReady;
      @(posedge clk); #1;
      if (sending) inValid = 1'b0;
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL bp_count: got %0d exp 3", n); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (k >= n || got[k] !== 32'(k + 1)) begin errors++; $display("FAIL bp_order[%0d]: got %0d exp %0d", k, (k < n) ? got[k] : 32'hFFFF_FFFF, k + 1); end
    end
  endtask

  task automatic test_flush_illegal();
    logic [31:0] add_i;
    add_i = enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011);
    outReady = 1'b0;
    send(add_i, 32'h300, 32'd1, 32'd0);
    send(add_i, 32'h304, 32'd2, 32'd0);
    flush = 1'b1; inValid = 1'b1; inInstr = add_i;
    @(posedge clk); #1;
    flush = 1'b0; inValid = 1'b0;
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL flush_full_valid: got %b exp 0", outValid); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL flush_full_ready: got %b exp 1", inReady); end
    flush = 1'b1; inValid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; inValid = 1'b0;
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL flush_accept: got %b exp 0", outValid); end
    outReady = 1'b1;
    send(32'hFFFF_FFFF, 32'h310, 32'd0, 32'd0);
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_pulse: got %b exp 1", illegal); end
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL illegal_valid: got %b exp 0", outValid); end
    @(posedge clk); #1;
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_one_cycle: got %b exp 0", illegal); end
    flush = 1'b1;
    send(32'hFFFF_FFFF, 32'h314, 32'd0, 32'd0);
    flush = 1'b0;
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_flushed: got %b exp 0", illegal); end
  endtask

  task automatic test_reset_mid();
    outReady = 1'b0;
    send(enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011), 32'h400, 32'd8, 32'd0);
    send(enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011), 32'h404, 32'd9, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b exp 0", outValid); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b exp 1", inReady); end
    checks++; if (outPc !== 32'h0 || srca !== 32'h0) begin errors++; $display("FAIL midrst_data: got pc=%h srca=%h exp 0/0", outPc, srca); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    outReady = 1'b1;
    @(posedge clk); #1;
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL midrst_after: got %b exp 0", outValid); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_forward();
    test_shift_imm();
    test_branch_jump();
    test_back_to_back();
    test_flush_illegal();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
